uart_core_param: RTL

// Single-clock, parametrised UART transmitter/receiver pair. Successor to the x16 UART: fixed 8E1 framing becomes a

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_core_param_if.sv | 24 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_core_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM state types and parity helpers.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop,
        RxBreak
    } rx_state_e;

    // Mode 3 is an alias for "no parity".
    function automatic logic parity_en(logic [1:0] mode);
        return !(mode == PAR_NONE || mode == 2'd3);
    endfunction

    // Data narrower than 8 bits is zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(logic [7:0] data, logic [1:0] mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// Byte-level handshake bundle between the UART core and its bus-side user.
interface uart_core_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_error;
    logic                 frame_error;
    logic                 overrun_error;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, parity_error, frame_error, overrun_error
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, parity_error, frame_error, overrun_error
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle tick every max(baud_div,1) clocks, restarted on any divisor change.
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] last;

    always_comb begin
        last  = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
        cnt_d = cnt_q + DIV_W'(1);
        tick  = 1'b0;
        if (baud_div != div_q) begin
            cnt_d = '0;
        end else if (cnt_q >= last) begin
            cnt_d = '0;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= baud_div;
        end else begin
            cnt_q <= cnt_d;
            div_q <= baud_div;
        end
    end
endmodule

// File: rtl/uart_core_param.sv
// UART transmitter/receiver pair with configurable framing, sharing one oversampling baud tick.
module uart_core_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    output logic             txd,
    input  logic             rxd,
    uart_core_param_if.slave bus
);
    localparam int unsigned   CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TLast    = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] TMid     = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] TMidM1   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] TMidM2   = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [3:0]    DataLast = 4'(DATA_BITS - 1);

    logic tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk_in  (clk_in),
        .rst     (rst),
        .baud_div(baud_div),
        .tick    (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_pbit_q, tx_pbit_d;
    logic                 tx_two_q, tx_two_d;
    logic [CW-1:0]        tx_tcnt_q, tx_tcnt_d;
    logic [3:0]           tx_bcnt_q, tx_bcnt_d;
    logic                 txd_q, txd_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pbit_d  = tx_pbit_q;
        tx_two_d   = tx_two_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        case (tx_state_q)
            TxIdle: begin
                if (bus.tx_valid) begin
                    tx_state_d = TxStart;
                    tx_shift_d = bus.tx_data;
                    tx_par_d   = parity_en(parity_mode);
                    tx_pbit_d  = parity_bit(8'(bus.tx_data), parity_mode);
                    tx_two_d   = two_stop;
                    tx_tcnt_d  = '0;
                    tx_bcnt_d  = '0;
                end
            end
            default: begin
                if (tick) begin
                    tx_tcnt_d = tx_tcnt_q + CW'(1);
                    if (tx_tcnt_q == TLast) begin
                        tx_tcnt_d = '0;
                        case (tx_state_q)
                            TxStart: tx_state_d = TxData;
                            TxData: begin
                                tx_shift_d = tx_shift_q >> 1;
                                tx_bcnt_d  = tx_bcnt_q + 4'd1;
                                if (tx_bcnt_q == DataLast) begin
                                    tx_bcnt_d  = '0;
                                    tx_state_d = tx_par_q ? TxParity : TxStop;
                                end
                            end
                            TxParity: tx_state_d = TxStop;
                            default: begin
                                // bcnt marks that the first of two stop bits has been sent
                                tx_bcnt_d = 4'd1;
                                if (!tx_two_q || tx_bcnt_q != '0) tx_state_d = TxIdle;
                            end
                        endcase
                    end
                end
            end
        endcase

        // Line level is registered from the next state so txd never glitches.
        unique case (tx_state_d)
            TxStart:  txd_d = 1'b0;
            TxData:   txd_d = tx_shift_d[0];
            TxParity: txd_d = tx_pbit_d;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_pbit_q  <= 1'b0;
            tx_two_q   <= 1'b0;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_pbit_q  <= tx_pbit_d;
            tx_two_q   <= tx_two_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            txd_q      <= txd_d;
        end
    end

    assign txd          = txd_q;
    assign bus.tx_ready = (tx_state_q == TxIdle);

    // ---------------- receiver ----------------
    logic                 sync1_q, sync2_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_tcnt_q, rx_tcnt_d;
    logic [3:0]           rx_bcnt_q, rx_bcnt_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 rx_perr_q, rx_perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 rx_line, vote, frame_done, stop_low;

    assign rx_line = sync2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_shift_d = rx_shift_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        rx_perr_d  = rx_perr_q;
        frame_done = 1'b0;
        stop_low   = 1'b0;
        vote       = (s0_q & s1_q) | (s0_q & rx_line) | (s1_q & rx_line);
        if (tick) begin
            case (rx_state_q)
                RxIdle: begin
                    if (!rx_line) begin
                        rx_state_d = RxStart;
                        rx_tcnt_d  = CW'(1);
                        rx_bcnt_d  = '0;
                        rx_perr_d  = 1'b0;
                    end
                end
                RxBreak: if (rx_line) rx_state_d = RxIdle;
                default: begin
                    rx_tcnt_d = (rx_tcnt_q == TLast) ? '0 : rx_tcnt_q + CW'(1);
                    if (rx_tcnt_q == TMidM2) s0_d = rx_line;
                    if (rx_tcnt_q == TMidM1) s1_d = rx_line;
                    case (rx_state_q)
                        RxStart: begin
                            if (rx_tcnt_q == TMidM1 && rx_line) rx_state_d = RxIdle;
                            else if (rx_tcnt_q == TLast) rx_state_d = RxData;
                        end
                        RxData: begin
                            if (rx_tcnt_q == TMid) rx_shift_d = {vote, rx_shift_q[DATA_BITS-1:1]};
                            if (rx_tcnt_q == TLast) begin
                                rx_bcnt_d = rx_bcnt_q + 4'd1;
                                if (rx_bcnt_q == DataLast) begin
                                    rx_state_d = parity_en(parity_mode) ? RxParity : RxStop;
                                end
                            end
                        end
                        RxParity: begin
                            if (rx_tcnt_q == TMid) begin
                                rx_perr_d = vote ^ parity_bit(8'(rx_shift_q), parity_mode);
                            end
                            if (rx_tcnt_q == TLast) rx_state_d = RxStop;
                        end
                        default: begin
                            // Stop bit: finish at mid-bit; a low stop holds RX until the line idles.
                            if (rx_tcnt_q == TMid) begin
                                frame_done = 1'b1;
                                stop_low   = !vote;
                                rx_state_d = vote ? RxIdle : RxBreak;
                            end
                        end
                    endcase
                end
            endcase
        end

        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
            ovr_d      = 1'b0;
        end
        if (frame_done) begin
            if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = rx_shift_q;
                perr_d     = rx_perr_q;
                ferr_d     = stop_low;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= RxIdle;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_shift_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            rx_perr_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_shift_q <= rx_shift_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            rx_perr_q  <= rx_perr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.parity_error  = perr_q;
    assign bus.frame_error   = ferr_q;
    assign bus.overrun_error = ovr_q;
endmodule
